// File: rtl/burst_scheduler_pkg.sv
// Shared types and constants for the burst scheduler: state encoding,
// counter width, the smallest usable period, and the cycle-to-phase mapping.
package burst_scheduler_pkg;

    localparam int CNT_W = 32;

    // A period needs at least two cycles so that cnt==T-1 is distinct from cnt==0.
    localparam logic [CNT_W-1:0] MIN_PERIOD = 32'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GUARD    = 2'd3
    } schedState_e;

    // Maps a period-relative cycle index onto the phase it belongs to.
    // The payload end is formed in CNT_W+1 bits so a large P+B cannot wrap.
    // In continuous mode everything after the preamble is payload.
    // With P=0 and B=0 the period has no active cycles and starts in GUARD.
    function automatic schedState_e phaseForCount(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] preLen,
        input logic [CNT_W-1:0] payLen,
        input logic             continuous
    );
        logic [CNT_W:0] payEnd;
        schedState_e    phase;
        payEnd = {1'b0, preLen} + {1'b0, payLen};
        if (cnt < preLen) begin
            phase = PREAMBLE;
        end else if (continuous || ({1'b0, cnt} < payEnd)) begin
            phase = PAYLOAD;
        end else begin
            phase = GUARD;
        end
        return phase;
    endfunction

endpackage

// File: rtl/burst_scheduler.sv
// Periodic burst scheduler: each period of T cycles is split into a preamble
// (P cycles), a payload (B cycles) and a guard remainder. Configuration is
// shadowed at period boundaries so mid-period input changes never disturb the
// burst in flight. Continuous mode keeps the payload running across wraps.
module burst_scheduler
    import burst_scheduler_pkg::*;
(
    input  logic             hb0_gtwiz_userclk_tx_usrclk2_int,
    input  logic             hb0_gtwiz_reset_n_int,
    input  logic             sched_enable,
    input  logic [CNT_W-1:0] preamble_length_vio_int,
    input  logic [CNT_W-1:0] burst_length_vio_int,
    input  logic [CNT_W-1:0] burst_period_vio_int,
    input  logic             b2bcontrol,
    output logic             burst_en,
    output logic             preamble_active,
    output logic             payload_active,
    output logic             burst_start,
    output logic [CNT_W-1:0] burst_count,
    output logic             config_err
);

    schedState_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] preLen_q, preLen_d;
    logic [CNT_W-1:0] payLen_q, payLen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             continuous_q, continuous_d;
    logic [CNT_W-1:0] burstCount_q, burstCount_d;
    logic             configErr_q, configErr_d;

    logic             preambleActive_q, preambleActive_d;
    logic             payloadActive_q, payloadActive_d;
    logic             burstEn_q, burstEn_d;
    logic             burstStart_q, burstStart_d;

    logic [CNT_W-1:0] cntNext;
    logic             lastCycle;
    logic             periodInValid;

    assign cntNext       = cnt_q + 32'd1;
    assign lastCycle     = (cnt_q == (period_q - 32'd1));
    assign periodInValid = (burst_period_vio_int >= MIN_PERIOD);

    // Next-state logic: period counting, shadow capture, continuous-mode hold
    // and the registered-output decode of the state being entered.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        preLen_d         = preLen_q;
        payLen_d         = payLen_q;
        period_d         = period_q;
        continuous_d     = continuous_q;
        burstCount_d     = burstCount_q;
        configErr_d      = configErr_q;
        burstStart_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sched_enable) begin
                    if (periodInValid) begin
                        preLen_d     = preamble_length_vio_int;
                        payLen_d     = burst_length_vio_int;
                        period_d     = burst_period_vio_int;
                        continuous_d = b2bcontrol;
                        configErr_d  = 1'b0;
                        burstStart_d = 1'b1;
                        burstCount_d = burstCount_q + 32'd1;
                        state_d      = phaseForCount('0, preamble_length_vio_int,
                                                     burst_length_vio_int, b2bcontrol);
                    end else begin
                        configErr_d = 1'b1;
                    end
                end
            end

            default: begin
                if (lastCycle) begin
                    // The period always completes; what follows depends on
                    // the enable and the configuration present at the wrap.
                    if (!sched_enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!periodInValid) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        configErr_d = 1'b1;
                    end else begin
                        preLen_d     = preamble_length_vio_int;
                        payLen_d     = burst_length_vio_int;
                        period_d     = burst_period_vio_int;
                        continuous_d = b2bcontrol;
                        configErr_d  = 1'b0;
                        cnt_d        = '0;
                        burstStart_d = 1'b1;
                        burstCount_d = burstCount_q + 32'd1;
                        // An ongoing continuous payload rides through the wrap;
                        // otherwise the new period starts from its own mapping.
                        if (continuous_q && b2bcontrol && (state_q == PAYLOAD)) begin
                            state_d = PAYLOAD;
                        end else begin
                            state_d = phaseForCount('0, preamble_length_vio_int,
                                                    burst_length_vio_int, b2bcontrol);
                        end
                    end
                end else begin
                    cnt_d = cntNext;
                    if (continuous_q && (state_q == PAYLOAD)) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = phaseForCount(cntNext, preLen_q, payLen_q, continuous_q);
                    end
                end
            end
        endcase

        preambleActive_d = (state_d == PREAMBLE);
        payloadActive_d  = (state_d == PAYLOAD);
        burstEn_d        = preambleActive_d | payloadActive_d;
    end

    // State, counter, shadow configuration and burst counter registers.
    always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n_int) begin
        if (!hb0_gtwiz_reset_n_int) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            preLen_q     <= '0;
            payLen_q     <= '0;
            period_q     <= '0;
            continuous_q <= 1'b0;
            burstCount_q <= '0;
            configErr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            preLen_q     <= preLen_d;
            payLen_q     <= payLen_d;
            period_q     <= period_d;
            continuous_q <= continuous_d;
            burstCount_q <= burstCount_d;
            configErr_q  <= configErr_d;
        end
    end

    // Output flops, loaded alongside the state so they describe the current cycle;
    // the async clear drops the laser enable as soon as reset asserts.
    always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n_int) begin
        if (!hb0_gtwiz_reset_n_int) begin
            preambleActive_q <= 1'b0;
            payloadActive_q  <= 1'b0;
            burstEn_q        <= 1'b0;
            burstStart_q     <= 1'b0;
        end else begin
            preambleActive_q <= preambleActive_d;
            payloadActive_q  <= payloadActive_d;
            burstEn_q        <= burstEn_d;
            burstStart_q     <= burstStart_d;
        end
    end

    assign burst_en        = burstEn_q;
    assign preamble_active = preambleActive_q;
    assign payload_active  = payloadActive_q;
    assign burst_start     = burstStart_q;
    assign burst_count     = burstCount_q;
    assign config_err      = configErr_q;

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler: each scenario task drives its own
// vectors and compares against hand-derived cycle maps at the falling edge.
module tb_burst_scheduler;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        schedEnable = 1'b0;
    logic        b2b = 1'b0;
    logic [31:0] preLen = '0;
    logic [31:0] payLen = '0;
    logic [31:0] period = '0;

    logic        burstEn;
    logic        preambleActive;
    logic        payloadActive;
    logic        burstStart;
    logic [31:0] burstCount;
    logic        configErr;

    int errors = 0;
    int checks = 0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    burst_scheduler dut (
        .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
        .hb0_gtwiz_reset_n_int            (rstN),
        .sched_enable                     (schedEnable),
        .preamble_length_vio_int          (preLen),
        .burst_length_vio_int             (payLen),
        .burst_period_vio_int             (period),
        .b2bcontrol                       (b2b),
        .burst_en                         (burstEn),
        .preamble_active                  (preambleActive),
        .payload_active                   (payloadActive),
        .burst_start                      (burstStart),
        .burst_count                      (burstCount),
        .config_err                       (configErr)
    );

    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] b,
                                 input logic [31:0] t, input logic en, input logic cont);
        preLen      = p;
        payLen      = b;
        period      = t;
        schedEnable = en;
        b2b         = cont;
    endtask

    task automatic doReset();
        @(negedge clk);
        schedEnable = 1'b0;
        rstN        = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Returns on the falling edge of the cycle where burst_start is seen (cnt 0).
    task automatic waitForStart(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (burstStart === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: burst_start actual=0 required=1 within 64 cycles", name);
        end
    endtask

    task automatic test_reset();
        applyStimulus(32'd4, 32'd10, 32'd20, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({burstEn, preambleActive, payloadActive, burstStart, configErr} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_flags: actual=%b required=00000",
                     {burstEn, preambleActive, payloadActive, burstStart, configErr});
        end
        checks++;
        if (burstCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: actual=%0d required=0", burstCount);
        end
        schedEnable = 1'b0;
    endtask

    task automatic test_basic();
        int          cnt;
        logic [3:0]  want;
        logic [3:0]  obs;
        logic [31:0] wantCount;
        doReset();
        applyStimulus(32'd4, 32'd10, 32'd20, 1'b1, 1'b0);
        waitForStart("basic_start");
        for (int c = 0; c < 65; c++) begin
            if (c > 0) @(negedge clk);
            cnt = c % 20;
            if (c < 60) begin
                want = {(cnt < 14), (cnt < 4), (cnt >= 4 && cnt < 14), (cnt == 0)};
                wantCount = 32'(c / 20 + 1);
            end else begin
                want = 4'b0000;
                wantCount = 32'd3;
            end
            obs = {burstEn, preambleActive, payloadActive, burstStart};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL basic_flags c=%0d: actual=%b required=%b", c, obs, want);
            end
            checks++;
            if (burstCount !== wantCount) begin
                errors++;
                $display("[TB] FAIL basic_count c=%0d: actual=%0d required=%0d", c, burstCount, wantCount);
            end
            if (c == 45) schedEnable = 1'b0;
        end
    endtask

    task automatic test_no_guard();
        int          cnt;
        logic [3:0]  want;
        logic [3:0]  obs;
        doReset();
        applyStimulus(32'd8, 32'd20, 32'd16, 1'b1, 1'b0);
        waitForStart("noguard_start");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            cnt = c % 16;
            want = {1'b1, (cnt < 8), (cnt >= 8), (cnt == 0)};
            obs = {burstEn, preambleActive, payloadActive, burstStart};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL noguard_flags c=%0d: actual=%b required=%b", c, obs, want);
            end
        end
        checks++;
        if (burstCount !== 32'd2) begin
            errors++;
            $display("[TB] FAIL noguard_count: actual=%0d required=2", burstCount);
        end
        schedEnable = 1'b0;
    endtask

    task automatic test_config_err();
        doReset();
        applyStimulus(32'd4, 32'd10, 32'd1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({configErr, burstEn, burstStart} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL cfg_short_period: actual=%b required=100", {configErr, burstEn, burstStart});
        end
        period = 32'd20;
        waitForStart("cfg_restart");
        checks++;
        if ({configErr, preambleActive, burstCount} !== {2'b01, 32'd1}) begin
            errors++;
            $display("[TB] FAIL cfg_recover: actual err=%b pre=%b count=%0d required err=0 pre=1 count=1",
                     configErr, preambleActive, burstCount);
        end
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) period = 32'd1;
        end
        checks++;
        if ({configErr, burstEn} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL cfg_midperiod_guard: actual=%b required=00", {configErr, burstEn});
        end
        @(negedge clk);
        checks++;
        if ({configErr, burstEn, burstStart} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL cfg_wrap_invalid: actual=%b required=100", {configErr, burstEn, burstStart});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({configErr, burstEn, burstCount} !== {2'b10, 32'd1}) begin
            errors++;
            $display("[TB] FAIL cfg_stay_idle: actual err=%b en=%b count=%0d required err=1 en=0 count=1",
                     configErr, burstEn, burstCount);
        end
        period = 32'd20;
        waitForStart("cfg_restart2");
        checks++;
        if ({configErr, burstCount} !== {1'b0, 32'd2}) begin
            errors++;
            $display("[TB] FAIL cfg_recover2: actual err=%b count=%0d required err=0 count=2", configErr, burstCount);
        end
        schedEnable = 1'b0;
    endtask

    task automatic test_shadow_update();
        int          cnt;
        int          payEnd;
        logic [3:0]  want;
        logic [3:0]  obs;
        logic [31:0] wantCount;
        doReset();
        applyStimulus(32'd4, 32'd10, 32'd20, 1'b1, 1'b0);
        waitForStart("shadow_start");
        for (int c = 0; c < 43; c++) begin
            if (c > 0) @(negedge clk);
            cnt = c % 20;
            payEnd = (c < 20) ? 14 : 9;
            if (c < 40) begin
                want = {(cnt < payEnd), (cnt < 4), (cnt >= 4 && cnt < payEnd), (cnt == 0)};
                wantCount = 32'(c / 20 + 1);
            end else begin
                want = 4'b0000;
                wantCount = 32'd2;
            end
            obs = {burstEn, preambleActive, payloadActive, burstStart};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL shadow_flags c=%0d: actual=%b required=%b", c, obs, want);
            end
            checks++;
            if (burstCount !== wantCount) begin
                errors++;
                $display("[TB] FAIL shadow_count c=%0d: actual=%0d required=%0d", c, burstCount, wantCount);
            end
            if (c == 6) payLen = 32'd5;
            if (c == 39) begin
                payLen      = 32'd2;
                preLen      = 32'd0;
                schedEnable = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cnt;
        logic [3:0]  want;
        logic [3:0]  obs;
        logic [31:0] wantCount;
        doReset();
        applyStimulus(32'd4, 32'd10, 32'd20, 1'b1, 1'b1);
        waitForStart("b2b_start");
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            cnt = c % 20;
            if (c < 80) begin
                want = {1'b1, (c < 4), (c >= 4), (cnt == 0)};
            end else begin
                want = {(cnt < 14), (cnt < 4), (cnt >= 4 && cnt < 14), (cnt == 0)};
            end
            wantCount = 32'(c / 20 + 1);
            obs = {burstEn, preambleActive, payloadActive, burstStart};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL b2b_flags c=%0d: actual=%b required=%b", c, obs, want);
            end
            checks++;
            if (burstCount !== wantCount) begin
                errors++;
                $display("[TB] FAIL b2b_count c=%0d: actual=%0d required=%0d", c, burstCount, wantCount);
            end
            if (c == 75) b2b = 1'b0;
            if (c == 99) schedEnable = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst();
        doReset();
        applyStimulus(32'd4, 32'd10, 32'd20, 1'b1, 1'b0);
        waitForStart("rstmid_start");
        repeat (7) @(negedge clk);
        checks++;
        if ({burstEn, payloadActive} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rstmid_before: actual=%b required=11", {burstEn, payloadActive});
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({burstEn, payloadActive, burstCount} !== {2'b00, 32'd0}) begin
            errors++;
            $display("[TB] FAIL rstmid_async: actual en=%b pay=%b count=%0d required en=0 pay=0 count=0",
                     burstEn, payloadActive, burstCount);
        end
        @(negedge clk);
        rstN = 1'b1;
        waitForStart("rstmid_restart");
        checks++;
        if ({preambleActive, burstCount} !== {1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL rstmid_resume: actual pre=%b count=%0d required pre=1 count=1",
                     preambleActive, burstCount);
        end
        schedEnable = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] burst_scheduler directed bench starting");
        test_reset();
        test_basic();
        test_no_guard();
        test_config_err();
        test_shadow_update();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time actual=200000ns required=finished earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
